period_to_freq: RTL and testbench

- Sequential unsigned divider that converts a measured period in microseconds into a frequency in Hz: freq = DIVIDEND / period.
- Sits directly downstream of the period counter.
- Its start is driven by the counter's done_tick, and its period input comes from the counter's 20-bit period output.
- Result goes to the display/BCD stage with a single-cycle done_tick.

---
 rtl/freq_meter_pkg.sv | 24 ++
 rtl/period_to_freq_if.sv | 40 ++++
 rtl/period_to_freq.sv | 119 +++++++++++
 tb/tb_period_to_freq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency-meter datapath: period counter,
// period-to-frequency divider and display stages.
// Contents: data width W, DIVIDEND (microseconds per second), the divider
// iteration counter width CNT_W, the divider state encoding, and the
// divider result record.
package freq_meter_pkg;

  localparam int unsigned W        = 20;
  localparam int unsigned DIVIDEND = 1_000_000;
  localparam int unsigned CNT_W    = $clog2(W);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOp   = 2'b01,
    StDone = 2'b10
  } div_state_e;

  typedef struct packed {
    logic [W-1:0] freq;
    logic [W-1:0] rem;
    logic         err;
  } div_result_t;

endpackage

// File: rtl/period_to_freq_if.sv
// Request/result bundle between the period counter (master) and the
// period-to-frequency divider (slave).
//   start     : conversion request, honoured only while ready=1
//   period    : divisor in microseconds
//   ready     : divider idle
//   done_tick : one-cycle pulse; freq/rem/div_err are valid from this cycle
//   freq, rem : quotient and remainder of DIVIDEND / period
//   div_err   : last conversion saw period == 0
interface period_to_freq_if;
  import freq_meter_pkg::*;

  logic         start;
  logic [W-1:0] period;
  logic         ready;
  logic         done_tick;
  logic [W-1:0] freq;
  logic [W-1:0] rem;
  logic         div_err;

  modport master (
    output start,
    output period,
    input  ready,
    input  done_tick,
    input  freq,
    input  rem,
    input  div_err
  );

  modport slave (
    input  start,
    input  period,
    output ready,
    output done_tick,
    output freq,
    output rem,
    output div_err
  );

endinterface

// File: rtl/period_to_freq.sv
// Sequential restoring divider: freq = DIVIDEND / period, one quotient bit
// per clock.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of period_to_freq_if (start/period in, ready,
//           done_tick, freq, rem, div_err out)
// A nonzero conversion takes W iterations after the accepting edge; a zero
// period short-circuits straight to DONE with freq all ones and div_err set.
// Results hold until the next DONE; they are not cleared by a new start.
module period_to_freq
  import freq_meter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  period_to_freq_if.slave         bus
);

  // The quotient is loaded with DIVIDEND, so it must fit in W bits.
  if (DIVIDEND >= (64'd1 << W)) begin : g_dividend_check
    $error("DIVIDEND does not fit in W bits");
  end

  div_state_e       state_q, state_d;
  logic [W-1:0]     divisor_q, divisor_d;
  logic [W-1:0]     quot_q, quot_d;      // dividend bits shift out, quotient bits shift in
  logic [W:0]       part_q, part_d;      // partial remainder, one spare bit for the compare
  logic [CNT_W-1:0] cnt_q, cnt_d;
  div_result_t      res_q, res_d;

  logic [W:0]       r_shift;
  logic [W:0]       r_sub;
  logic             fits;
  logic [W-1:0]     quot_next;
  logic [W:0]       part_next;

  // Single restoring step.
  always_comb begin
    r_shift   = {part_q[W-1:0], quot_q[W-1]};
    r_sub     = r_shift - {1'b0, divisor_q};
    fits      = (r_shift >= {1'b0, divisor_q});
    part_next = fits ? r_sub : r_shift;
    quot_next = {quot_q[W-2:0], fits};
  end

  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    part_d    = part_q;
    cnt_d     = cnt_q;
    res_d     = res_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          divisor_d = bus.period;
          quot_d    = W'(DIVIDEND);
          part_d    = '0;
          cnt_d     = '0;
          if (bus.period == '0) begin
            res_d.freq = '1;
            res_d.rem  = '0;
            res_d.err  = 1'b1;
            state_d    = StDone;
          end else begin
            state_d = StOp;
          end
        end
      end

      StOp: begin
        part_d = part_next;
        quot_d = quot_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          // Remainder is below the divisor, so the top bit is always zero.
          res_d.freq = quot_next;
          res_d.rem  = part_next[W-1:0];
          res_d.err  = 1'b0;
          state_d    = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      divisor_q <= '0;
      quot_q    <= '0;
      part_q    <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      part_q    <= part_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
    end
  end

  assign bus.ready     = (state_q == StIdle);
  assign bus.done_tick = (state_q == StDone);
  assign bus.freq      = res_q.freq;
  assign bus.rem       = res_q.rem;
  assign bus.div_err   = res_q.err;

endmodule

// File: tb/tb_period_to_freq.sv
// Self-checking bench for period_to_freq. Every accepted start pushes the
// expected result (from integer division) onto a queue; a monitor pops and
// compares on each done_tick. Scenario tasks check timing, ready and
// reset behaviour inline.
module tb_period_to_freq;

  localparam int unsigned TW  = 20;
  localparam int unsigned DIV = 1_000_000;

  typedef struct {
    logic [TW-1:0] freq;
    logic [TW-1:0] rem;
    logic          err;
  } exp_t;

  logic clk;
  logic rst_n;

  period_to_freq_if bus ();

  period_to_freq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  function automatic exp_t model(input logic [TW-1:0] p);
    exp_t e;
    if (p == '0) begin
      e.freq = '1;
      e.rem  = '0;
      e.err  = 1'b1;
    end else begin
      e.freq = TW'(DIV / int'(p));
      e.rem  = TW'(DIV % int'(p));
      e.err  = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor.
  always @(posedge clk) begin
    #1;
    if (bus.done_tick) begin
      exp_t e;
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done_tick with no pending request (freq=%0d)", bus.freq);
      end else begin
        e = exp_q.pop_front();
        checks += 2;
        if (bus.freq !== e.freq) begin
          errors++;
          $display("FAIL freq: got %0d expected %0d", bus.freq, e.freq);
        end
        if (bus.rem !== e.rem) begin
          errors++;
          $display("FAIL rem: got %0d expected %0d", bus.rem, e.rem);
        end
        if (bus.div_err !== e.err) begin
          errors++;
          $display("FAIL div_err: got %0b expected %0b", bus.div_err, e.err);
        end
      end
    end
  end

  // Waits for ready, presents one start pulse, records the expectation.
  // Returns at #1 after the accepting edge.
  task automatic issue(input logic [TW-1:0] p);
    int n = 0;
    while (!bus.ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    bus.start  = 1'b1;
    bus.period = p;
    exp_q.push_back(model(p));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges from now until done_tick is visible.
  task automatic wait_done(input int budget, output int edges, output bit timeout);
    edges = 0;
    while (!bus.done_tick && edges < budget) begin
      @(posedge clk);
      #1;
      edges++;
    end
    timeout = !bus.done_tick;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.period = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready);
    end
    if (bus.done_tick !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b expected 0", bus.done_tick);
    end
    if (bus.freq !== '0) begin
      errors++; $display("FAIL reset_freq: got %0d expected 0", bus.freq);
    end
    if (bus.rem !== '0) begin
      errors++; $display("FAIL reset_rem: got %0d expected 0", bus.rem);
    end
    if (bus.div_err !== 1'b0) begin
      errors++; $display("FAIL reset_div_err: got %b expected 0", bus.div_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_period_one();
    int e;
    bit to;
    issue(20'd1);
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL one_ready_drop: got %b expected 0", bus.ready);
    end
    // Start edge plus 20 further edges: 21 edges counting the start edge.
    wait_done(100, e, to);
    checks++;
    if (to || e != 20) begin
      errors++; $display("FAIL one_latency: got %0d edges after start edge expected 20", e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL one_ready_back: got %b expected 1", bus.ready);
    end
  endtask

  task automatic test_values();
    int e;
    bit to;
    logic [TW-1:0] pv [3];
    pv[0] = 20'd1000;
    pv[1] = 20'd3;
    pv[2] = 20'hFFFFF;
    foreach (pv[i]) begin
      issue(pv[i]);
      wait_done(100, e, to);
      checks++;
      if (to) begin
        errors++; $display("FAIL values_timeout: period %0d got no done_tick", pv[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int e;
    bit to;
    issue(20'd0);
    wait_done(100, e, to);
    checks++;
    if (to || e != 0) begin
      errors++; $display("FAIL zero_latency: got %0d extra edges expected 0", e);
    end
    issue(20'd7);
    wait_done(100, e, to);
    checks++;
    if (to || e != 20) begin
      errors++; $display("FAIL seven_latency: got %0d edges expected 20", e);
    end
  endtask

  task automatic test_ignore_start();
    int e;
    bit to;
    int d0;
    d0 = done_cnt;
    issue(20'd100);
    repeat (5) begin
      @(negedge clk);
      bus.start  = 1'b1;
      bus.period = 20'd9;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checks++;
      if (bus.ready !== 1'b0) begin
        errors++; $display("FAIL ignore_ready: got %b expected 0 during OP", bus.ready);
      end
    end
    wait_done(100, e, to);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL ignore_count: got %0d done_ticks expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    bit to;
    int d0;
    issue(20'd12345);
    d0 = done_cnt;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    checks += 3;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready: got %b expected 1", bus.ready);
    end
    if (bus.freq !== '0) begin
      errors++; $display("FAIL rst_mid_freq: got %0d expected 0", bus.freq);
    end
    if (bus.rem !== '0) begin
      errors++; $display("FAIL rst_mid_rem: got %0d expected 0", bus.rem);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks += 2;
    if (done_cnt != d0) begin
      errors++; $display("FAIL rst_mid_no_done: got %0d done_ticks expected 0", done_cnt - d0);
    end
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_idle: got ready=%b expected 1", bus.ready);
    end
    issue(20'd250);
    wait_done(100, e, to);
    checks++;
    if (to) begin
      errors++; $display("FAIL rst_mid_fresh: got no done_tick for period 250");
    end
  endtask

  task automatic test_back_to_back();
    int e;
    bit to;
    int gap;
    issue(20'd2);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.period = 20'd5;
    exp_q.push_back(model(20'd5));
    wait_done(100, e, to);
    gap = 0;
    do begin
      @(posedge clk);
      #1;
      gap++;
      if (bus.start && !bus.ready) bus.start = 1'b0;
    end while (!bus.done_tick && gap < 100);
    bus.start = 1'b0;
    checks++;
    if (to || gap != 22) begin
      errors++; $display("FAIL b2b_gap: got %0d edges between done_ticks expected 22", gap);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_period_one();
    test_values();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending: got %0d outstanding results expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
